clk_div_bank: RTL and testbench

- Synthesizable bank of NUM_CH independent integer clock dividers driven from one system clock.
- Each channel produces a divided square-wave-style output, `clk_out`, and a one-cycle `tick` enable at its period end.
- Divisors are programmable at run time and take effect glitch-free at a period boundary.
- A global `sync` pulse phase-aligns all channels. The block replaces free-running bench dividers with one parametrised block usable in RTL and benches.

---
 rtl/clk_div_bank.sv | 133 +++++++++++++
 tb/tb_clk_div_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH independent integer clock dividers running
// from a single system clock.
//
// Each channel counts 0..div_act-1. Its output is high while the count is
// below div_act>>1, and tick marks the last count of each period.
// Divisor changes are staged in div_pend. They reach div_act only at a
// period boundary, so no runt or stretched half-period is ever produced.
// The three period boundaries are:
//   - a wrap while enabled,
//   - any edge while disabled,
//   - a sync edge.
//
// Write interface: div_we is a single-cycle strobe with no back-pressure.
// On every edge where div_we=1, {div_ch, div_in} is accepted and nothing is
// held over to later cycles. Writes to div_ch >= NUM_CH are dropped.
//
// Ports:
//   clk      in   system clock; all state updates on its rising edge
//   rst      in   asynchronous active-low reset
//   en       in   [NUM_CH] per-channel run enable
//   sync     in   single-cycle phase-realign strobe (enabled channels only)
//   div_we   in   divisor write strobe
//   div_ch   in   [CH_W] channel addressed by the write
//   div_in   in   [DIV_W] new divisor (values below 2 are stored as 2)
//   clk_out  out  [NUM_CH] divided clock per channel (registered)
//   tick     out  [NUM_CH] one-cycle pulse in each channel's last count
//   div_busy out  [NUM_CH] a written divisor is still waiting for a boundary
module clk_div_bank #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              div_we,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_in,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_busy
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  // A divide-by-0 or divide-by-1 has no meaningful square wave, so those
  // values are raised to 2.
  logic [DIV_W-1:0] div_clamped;
  assign div_clamped = (div_in < TWO) ? TWO : div_in;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] cnt, div_act, div_pend;
    logic [DIV_W-1:0] cnt_n, act_n, pend_n;
    logic             clk_q, tick_q, busy_q;
    logic             clk_n, tick_n, busy_n;
    logic             sel;

    // An out-of-range div_ch matches no channel, so that write is dropped.
    assign sel = div_we && (div_ch == CH_W'(c));

    always_comb begin
      cnt_n  = cnt;
      act_n  = div_act;
      pend_n = div_pend;
      busy_n = busy_q;
      clk_n  = clk_q;
      tick_n = tick_q;

      if (!en[c]) begin
        // Park at period end using the applied divisor. The first enabled
        // edge then wraps to 0 and raises the clock, just as after reset.
        act_n  = div_pend;
        busy_n = 1'b0;
        cnt_n  = div_pend - ONE;
        clk_n  = 1'b0;
        tick_n = 1'b0;
      end else if (sync) begin
        act_n  = div_pend;
        busy_n = 1'b0;
        cnt_n  = '0;
        clk_n  = 1'b1;
        tick_n = 1'b0;
      end else begin
        if (cnt == div_act - ONE) begin
          act_n  = div_pend;
          busy_n = 1'b0;
          cnt_n  = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
        // Decode the outputs from the count and divisor that the new
        // period will use, so a divisor change takes effect exactly at
        // the wrap.
        clk_n  = (cnt_n < (act_n >> 1));
        tick_n = (cnt_n == act_n - ONE);
      end

      // A write on a boundary edge is applied at the following boundary.
      // The boundary above has already consumed the old pending value.
      if (sel) begin
        pend_n = div_clamped;
        busy_n = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt      <= DEF_DIV - ONE;
        div_act  <= DEF_DIV;
        div_pend <= DEF_DIV;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        cnt      <= cnt_n;
        div_act  <= act_n;
        div_pend <= pend_n;
        clk_q    <= clk_n;
        tick_q   <= tick_n;
        busy_q   <= busy_n;
      end
    end

    assign clk_out[c]  = clk_q;
    assign tick[c]     = tick_q;
    assign div_busy[c] = busy_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank (NUM_CH=3, DIV_W=8, DEFAULT_DIV=2).
//
// The reference model tracks, for each channel:
//   - the position inside the current period,
//   - the active divisor and the pending divisor,
//   - the pending flag.
// Expected outputs come from the waveform rules: the output is high for the
// first N/2 cycles of each period, and tick is high in the last cycle.
module tb_clk_div_bank;
  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           sync = 1'b0;
  logic           div_we = 1'b0;
  logic [1:0]     div_ch = '0;
  logic [7:0]     div_in = '0;
  logic [NCH-1:0] clk_out, tick, div_busy;

  clk_div_bank #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_we(div_we),
    .div_ch(div_ch), .div_in(div_in), .clk_out(clk_out), .tick(tick),
    .div_busy(div_busy)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_act[NCH], m_pend[NCH], m_pos[NCH];
  bit m_clk[NCH], m_tick[NCH], m_busy[NCH];

  // DUT edge/tick counters used by the period checks
  int rises[NCH], ticks[NCH];
  bit prev_clk[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 2; m_pend[c] = 2; m_pos[c] = 1;
      m_clk[c] = 0; m_tick[c] = 0; m_busy[c] = 0;
    end
  endtask

  // Advance the model by one edge, using the inputs currently driven.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        m_act[c] = m_pend[c]; m_busy[c] = 0;
        m_pos[c] = m_act[c] - 1; m_clk[c] = 0; m_tick[c] = 0;
      end else if (sync) begin
        m_act[c] = m_pend[c]; m_busy[c] = 0;
        m_pos[c] = 0; m_clk[c] = 1; m_tick[c] = 0;
      end else begin
        m_pos[c]++;
        if (m_pos[c] >= m_act[c]) begin
          m_pos[c] = 0; m_act[c] = m_pend[c]; m_busy[c] = 0;
        end
        m_clk[c]  = (m_pos[c] < m_act[c] / 2);
        m_tick[c] = (m_pos[c] == m_act[c] - 1);
      end
      if (div_we && int'(div_ch) == c) begin
        m_pend[c] = (div_in < 2) ? 2 : int'(div_in);
        m_busy[c] = 1;
      end
    end
  endtask

  // One clock: update the model, let the edge happen, then compare 1 ns later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_clk[c]));
      check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
      check($sformatf("div_busy[%0d]", c), 32'(div_busy[c]), 32'(m_busy[c]));
      if (clk_out[c] && !prev_clk[c]) rises[c]++;
      if (tick[c]) ticks[c]++;
      prev_clk[c] = clk_out[c];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      rises[c] = 0; ticks[c] = 0; prev_clk[c] = clk_out[c];
    end
  endtask

  task automatic write_div(input int ch, input int val);
    div_we = 1'b1; div_ch = 2'(ch); div_in = 8'(val);
    cycle();
    div_we = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < NCH; c++) prev_clk[c] = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset clk_out", 32'(clk_out), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset div_busy", 32'(div_busy), 32'd0);
    rst = 1'b1;

    // default divide-by-2 on all channels
    en = 3'b111;
    clear_counts();
    run(10);
    check("div2 ch0 rises", 32'(rises[0]), 32'd5);
    check("div2 ch2 ticks", 32'(ticks[2]), 32'd5);

    // mixed ratios, programmed while disabled
    en = 3'b000;
    cycle();
    write_div(1, 4);
    write_div(2, 8);
    cycle();
    en = 3'b111;
    clear_counts();
    run(80);
    check("div4 ch1 rises", 32'(rises[1]), 32'd20);
    check("div4 ch1 ticks", 32'(ticks[1]), 32'd20);
    check("div8 ch2 rises", 32'(rises[2]), 32'd10);
    check("div8 ch2 ticks", 32'(ticks[2]), 32'd10);

    // odd divisor, then a clamped write
    write_div(0, 5);
    run(30);
    write_div(0, 0);
    run(20);

    // glitch-free change: ch1 at 8, write 4 when the count reaches 2
    write_div(1, 8);
    for (int i = 0; i < 16 && m_busy[1]; i++) cycle();
    for (int i = 0; i < 16 && m_pos[1] != 2; i++) cycle();
    write_div(1, 4);
    run(24);

    // sync alignment with 3, 4 and 6
    write_div(0, 3);
    write_div(1, 4);
    write_div(2, 6);
    run(17);
    pulse_sync();
    check("sync all high", 32'(clk_out), 32'd7);
    run(12);
    check("sync +12 all high", 32'(clk_out), 32'd7);
    run(12);
    check("sync +24 all high", 32'(clk_out), 32'd7);

    // drop en[2] mid-period, then restart it
    run(2);
    en = 3'b011;
    run(5);
    en = 3'b111;
    run(8);

    // asynchronous reset between edges
    #3;
    rst = 1'b0;
    #1;
    check("async rst clk_out", 32'(clk_out), 32'd0);
    check("async rst tick", 32'(tick), 32'd0);
    check("async rst div_busy", 32'(div_busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) prev_clk[c] = 1'b0;
    run(6);

    // randomized traffic, including writes to the unused channel index 3
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) en = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 7) == 0) en = 3'b111;
      sync   = ($urandom_range(0, 40) == 0);
      div_we = ($urandom_range(0, 9) == 0);
      div_ch = 2'($urandom_range(0, 3));
      div_in = 8'($urandom_range(0, 12));
      cycle();
    end
    sync = 1'b0;
    div_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
